// File: rtl/load_queue_mc.sv
// Multi-channel load queue: allocate, optional store-queue forward lookup, dcache issue with retry, writeback.
// Define LQ_FWD_EN to include the FWD stage; otherwise loads go straight to the dcache.
module load_queue_mc #(
    parameter int NUM_IN  = 2,
    parameter int DEPTH   = 8,
    parameter int NUM_MEM = 2,
    parameter int TAG_W   = 6,
    parameter int ID_W    = $clog2(DEPTH) + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_IN-1:0]            alloc_valid,
    input  logic [NUM_IN-1:0][31:0]      alloc_addr,
    input  logic [NUM_IN-1:0][1:0]       alloc_size,
    input  logic [NUM_IN-1:0]            alloc_unsigned,
    input  logic [NUM_IN-1:0][TAG_W-1:0] alloc_tag,
    output logic [NUM_IN-1:0]            alloc_ready,
    output logic                         fwd_req,
    output logic [31:0]                  fwd_addr,
    output logic [1:0]                   fwd_size,
    input  logic                         fwd_hit,
    input  logic                         fwd_block,
    input  logic [31:0]                  fwd_data,
    output logic [NUM_MEM-1:0]           mem_req_valid,
    output logic [NUM_MEM-1:0][31:0]     mem_req_addr,
    output logic [NUM_MEM-1:0][ID_W-1:0] mem_req_id,
    input  logic [NUM_MEM-1:0]           mem_req_accept,
    input  logic [NUM_MEM-1:0]           mem_resp_valid,
    input  logic [NUM_MEM-1:0][ID_W-1:0] mem_resp_id,
    input  logic [NUM_MEM-1:0][31:0]     mem_resp_data,
    output logic                         done_valid,
    output logic [TAG_W-1:0]             done_tag,
    output logic [31:0]                  done_data,
    input  logic                         done_ack
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {S_FREE, S_FWD, S_MEM, S_WAIT, S_DONE} state_t;

`ifdef LQ_FWD_EN
    localparam state_t FIRST_STATE = S_FWD;
`else
    localparam state_t FIRST_STATE = S_MEM;
`endif

    state_t            state_q [DEPTH];
    state_t            state_d [DEPTH];
    logic              gen_q   [DEPTH];
    logic              gen_d   [DEPTH];
    logic [31:0]       addr_q  [DEPTH];
    logic [31:0]       addr_d  [DEPTH];
    logic [1:0]        size_q  [DEPTH];
    logic [1:0]        size_d  [DEPTH];
    logic              uns_q   [DEPTH];
    logic              uns_d   [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [TAG_W-1:0]  tag_d   [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [31:0]       data_d  [DEPTH];

    logic [CNT_W-1:0]  free_cnt;
    logic [CNT_W-1:0]  mem_cnt;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  free_rank [DEPTH];
    logic [CNT_W-1:0]  mem_rank  [DEPTH];
    logic [CNT_W-1:0]  acc_rank  [NUM_IN];
    logic [NUM_IN-1:0] acc;

    logic              done_found;
    logic              done_sel  [DEPTH];
    logic              mem_acc   [DEPTH];
    logic              resp_hit  [DEPTH];
    logic [31:0]       resp_word [DEPTH];
`ifdef LQ_FWD_EN
    logic              fwd_found;
    logic              fwd_sel   [DEPTH];
`else
    logic              unused_fwd_inputs;
    assign unused_fwd_inputs = ^{fwd_hit, fwd_block, fwd_data};
`endif

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Prefix counts: rank of each FREE/MEM entry and of each accepted channel.
    always_comb begin : rank_p
        free_cnt = '0;
        mem_cnt  = '0;
        acc_cnt  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            free_rank[e] = free_cnt;
            mem_rank[e]  = mem_cnt;
            if (state_q[e] == S_FREE) free_cnt = free_cnt + CNT_W'(1);
            if (state_q[e] == S_MEM)  mem_cnt  = mem_cnt + CNT_W'(1);
        end
        for (int i = 0; i < NUM_IN; i++) begin
            alloc_ready[i] = int'(free_cnt) > i;
            acc[i]         = alloc_valid[i] & alloc_ready[i];
            acc_rank[i]    = acc_cnt;
            if (acc[i]) acc_cnt = acc_cnt + CNT_W'(1);
        end
    end

    always_comb begin : select_p
        done_found = 1'b0;
`ifdef LQ_FWD_EN
        fwd_found  = 1'b0;
`endif
        for (int e = 0; e < DEPTH; e++) begin
            done_sel[e] = !done_found && (state_q[e] == S_DONE);
            if (state_q[e] == S_DONE) done_found = 1'b1;
`ifdef LQ_FWD_EN
            fwd_sel[e] = !fwd_found && (state_q[e] == S_FWD);
            if (state_q[e] == S_FWD) fwd_found = 1'b1;
`endif
            mem_acc[e] = 1'b0;
            for (int p = 0; p < NUM_MEM; p++) begin
                if (state_q[e] == S_MEM && mem_rank[e] == CNT_W'(p)) mem_acc[e] = mem_req_accept[p];
            end
            // A response may land in the same cycle its request is accepted.
            resp_hit[e]  = 1'b0;
            resp_word[e] = '0;
            for (int p = 0; p < NUM_MEM; p++) begin
                if (mem_resp_valid[p] && mem_resp_id[p] == {gen_q[e], IDX_W'(e)} &&
                    (state_q[e] == S_WAIT || mem_acc[e])) begin
                    resp_hit[e]  = 1'b1;
                    resp_word[e] = mem_resp_data[p];
                end
            end
        end
    end

    always_comb begin : next_state_p
        for (int e = 0; e < DEPTH; e++) begin
            state_d[e] = state_q[e];
            gen_d[e]   = gen_q[e];
            addr_d[e]  = addr_q[e];
            size_d[e]  = size_q[e];
            uns_d[e]   = uns_q[e];
            tag_d[e]   = tag_q[e];
            data_d[e]  = data_q[e];
            if (flush) begin
                state_d[e] = S_FREE;
            end else begin
                case (state_q[e])
                    S_FREE: begin
                        for (int i = 0; i < NUM_IN; i++) begin
                            if (acc[i] && acc_rank[i] == free_rank[e]) begin
                                state_d[e] = FIRST_STATE;
                                gen_d[e]   = ~gen_q[e];
                                addr_d[e]  = alloc_addr[i];
                                size_d[e]  = alloc_size[i];
                                uns_d[e]   = alloc_unsigned[i];
                                tag_d[e]   = alloc_tag[i];
                            end
                        end
                    end
`ifdef LQ_FWD_EN
                    S_FWD: begin
                        if (fwd_sel[e] && !fwd_block) begin
                            if (fwd_hit) begin
                                data_d[e]  = extract(fwd_data, addr_q[e][1:0], size_q[e], uns_q[e]);
                                state_d[e] = S_DONE;
                            end else begin
                                state_d[e] = S_MEM;
                            end
                        end
                    end
`endif
                    S_MEM, S_WAIT: begin
                        if (resp_hit[e]) begin
                            data_d[e]  = extract(resp_word[e], addr_q[e][1:0], size_q[e], uns_q[e]);
                            state_d[e] = S_DONE;
                        end else if (mem_acc[e]) begin
                            state_d[e] = S_WAIT;
                        end
                    end
                    S_DONE: begin
                        if (done_sel[e] && done_ack) state_d[e] = S_FREE;
                    end
                    default: state_d[e] = S_FREE;
                endcase
            end
        end
    end

    always_comb begin : output_p
        fwd_req       = 1'b0;
        fwd_addr      = '0;
        fwd_size      = '0;
        mem_req_valid = '0;
        mem_req_addr  = '0;
        mem_req_id    = '0;
        done_valid    = 1'b0;
        done_tag      = '0;
        done_data     = '0;
        for (int e = 0; e < DEPTH; e++) begin
`ifdef LQ_FWD_EN
            if (fwd_sel[e]) begin
                fwd_req  = 1'b1;
                fwd_addr = addr_q[e];
                fwd_size = size_q[e];
            end
`endif
            if (done_sel[e]) begin
                done_valid = 1'b1;
                done_tag   = tag_q[e];
                done_data  = data_q[e];
            end
            for (int p = 0; p < NUM_MEM; p++) begin
                if (state_q[e] == S_MEM && mem_rank[e] == CNT_W'(p)) begin
                    mem_req_valid[p] = 1'b1;
                    mem_req_addr[p]  = addr_q[e];
                    mem_req_id[p]    = {gen_q[e], IDX_W'(e)};
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (reset) begin
                    state_q[gi] <= S_FREE;
                    gen_q[gi]   <= 1'b0;
                    addr_q[gi]  <= '0;
                    size_q[gi]  <= '0;
                    uns_q[gi]   <= 1'b0;
                    tag_q[gi]   <= '0;
                    data_q[gi]  <= '0;
                end else begin
                    state_q[gi] <= state_d[gi];
                    gen_q[gi]   <= gen_d[gi];
                    addr_q[gi]  <= addr_d[gi];
                    size_q[gi]  <= size_d[gi];
                    uns_q[gi]   <= uns_d[gi];
                    tag_q[gi]   <= tag_d[gi];
                    data_q[gi]  <= data_d[gi];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_load_queue_mc.sv
// Self-checking bench for load_queue_mc: table-driven extraction vectors plus multi-cycle sequences.
// Forward-path sequences run only when LQ_FWD_EN is defined.
`timescale 1ns/1ps
module tb_load_queue_mc;
    localparam int NUM_IN  = 2;
    localparam int DEPTH   = 8;
    localparam int NUM_MEM = 2;
    localparam int TAG_W   = 6;
    localparam int ID_W    = 4;

    logic                         clock = 1'b0;
    logic                         reset, flush;
    logic [NUM_IN-1:0]            alloc_valid;
    logic [NUM_IN-1:0][31:0]      alloc_addr;
    logic [NUM_IN-1:0][1:0]       alloc_size;
    logic [NUM_IN-1:0]            alloc_unsigned;
    logic [NUM_IN-1:0][TAG_W-1:0] alloc_tag;
    logic [NUM_IN-1:0]            alloc_ready;
    logic                         fwd_req;
    logic [31:0]                  fwd_addr;
    logic [1:0]                   fwd_size;
    logic                         fwd_hit, fwd_block;
    logic [31:0]                  fwd_data;
    logic [NUM_MEM-1:0]           mem_req_valid;
    logic [NUM_MEM-1:0][31:0]     mem_req_addr;
    logic [NUM_MEM-1:0][ID_W-1:0] mem_req_id;
    logic [NUM_MEM-1:0]           mem_req_accept;
    logic [NUM_MEM-1:0]           mem_resp_valid;
    logic [NUM_MEM-1:0][ID_W-1:0] mem_resp_id;
    logic [NUM_MEM-1:0][31:0]     mem_resp_data;
    logic                         done_valid;
    logic [TAG_W-1:0]             done_tag;
    logic [31:0]                  done_data;
    logic                         done_ack;

    load_queue_mc #(.NUM_IN(NUM_IN), .DEPTH(DEPTH), .NUM_MEM(NUM_MEM), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_size(alloc_size),
        .alloc_unsigned(alloc_unsigned), .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
        .fwd_req(fwd_req), .fwd_addr(fwd_addr), .fwd_size(fwd_size),
        .fwd_hit(fwd_hit), .fwd_block(fwd_block), .fwd_data(fwd_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
        .mem_req_accept(mem_req_accept), .mem_resp_valid(mem_resp_valid),
        .mem_resp_id(mem_resp_id), .mem_resp_data(mem_resp_data),
        .done_valid(done_valid), .done_tag(done_tag), .done_data(done_data), .done_ack(done_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    int        n_checks = 0;
    int        n_fail   = 0;
    exp_t      sb_q[$];
    logic      gen_m [DEPTH];
    vec_t      vecs [9];
    logic [ID_W-1:0] stale_id;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [ID_W-1:0] id_of(input int e);
        logic [2:0] idx;
        idx = e[2:0];
        return {gen_m[e], idx};
    endfunction

    task automatic push(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        exp_t x;
        x.tag  = tag;
        x.data = data;
        sb_q.push_back(x);
    endtask

    task automatic clr_mem;
        mem_req_accept = '0;
        mem_resp_valid = '0;
        mem_resp_id    = '0;
        mem_resp_data  = '0;
    endtask

    task automatic alloc1(input int e, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [TAG_W-1:0] tag);
        alloc_valid       = 2'b01;
        alloc_addr[0]     = addr;
        alloc_size[0]     = size;
        alloc_unsigned[0] = uns;
        alloc_tag[0]      = tag;
        tick;
        alloc_valid = '0;
        gen_m[e]    = ~gen_m[e];
    endtask

    task automatic alloc2(input int e0, input int e1, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1);
        alloc_valid    = 2'b11;
        alloc_addr[0]  = a0;
        alloc_addr[1]  = a1;
        alloc_size     = {2'd2, 2'd2};
        alloc_unsigned = 2'b11;
        alloc_tag[0]   = t0;
        alloc_tag[1]   = t1;
        tick;
        alloc_valid = '0;
        gen_m[e0]   = ~gen_m[e0];
        gen_m[e1]   = ~gen_m[e1];
    endtask

    // Walk n entries through a forward miss (no-op when the FWD stage is absent).
    task automatic miss_cycles(input int n);
`ifdef LQ_FWD_EN
        for (int k = 0; k < n; k++) begin
            check("fwd_req_miss", 32'(fwd_req), 32'd1);
            fwd_hit   = 1'b0;
            fwd_block = 1'b0;
            tick;
        end
`else
        check("fwd_req_tied", 32'(fwd_req), 32'd0);
        if (n < 0) $display("negative miss count");
`endif
    endtask

    task automatic expect_req(input int p, input int e);
        check("mem_req_valid", 32'(mem_req_valid[p]), 32'd1);
        check("mem_req_id", 32'(mem_req_id[p]), 32'(id_of(e)));
    endtask

    task automatic accept_pair(input int e0, input int e1);
        check("mem_req_valid_pair", 32'(mem_req_valid), 32'd3);
        check("mem_req_id_p0", 32'(mem_req_id[0]), 32'(id_of(e0)));
        check("mem_req_id_p1", 32'(mem_req_id[1]), 32'(id_of(e1)));
        mem_req_accept = 2'b11;
        tick;
        clr_mem;
    endtask

    task automatic collect;
        int   t;
        exp_t x;
        t = 0;
        while (!done_valid && t < 20) begin
            tick;
            t++;
        end
        n_checks++;
        if (!done_valid) begin
            n_fail++;
            $display("FAIL done_timeout: done_valid=0, expected 1");
        end else if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: tag=%0d, expected no completion", done_tag);
        end else begin
            x = sb_q.pop_front();
            $display("done  tag=%0d data=0x%08h", done_tag, done_data);
            check("done_tag", 32'(done_tag), 32'(x.tag));
            check("done_data", done_data, x.data);
            done_ack = 1'b1;
            tick;
            done_ack = 1'b0;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_alloc_ready"}, 32'(alloc_ready), 32'd3);
        check({name, "_done_valid"}, 32'(done_valid), 32'd0);
        check({name, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({name, "_fwd_req"}, 32'(fwd_req), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0103, 2'd0, 1'b0, 32'h80FF_FF00, 32'hFFFF_FF80};
        vecs[1] = '{32'h0000_0202, 2'd1, 1'b1, 32'hABCD_1234, 32'h0000_ABCD};
        vecs[2] = '{32'h0000_0202, 2'd1, 1'b0, 32'hABCD_1234, 32'hFFFF_ABCD};
        vecs[3] = '{32'h0000_0300, 2'd1, 1'b0, 32'h1234_8765, 32'hFFFF_8765};
        vecs[4] = '{32'h0000_0300, 2'd1, 1'b1, 32'h1234_8765, 32'h0000_8765};
        vecs[5] = '{32'h0000_0400, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[6] = '{32'h0000_0401, 2'd0, 1'b0, 32'h0000_7F00, 32'h0000_007F};
        vecs[7] = '{32'h0000_0401, 2'd0, 1'b1, 32'h0000_FE00, 32'h0000_00FE};
        vecs[8] = '{32'h0000_0402, 2'd0, 1'b0, 32'h00C3_0000, 32'hFFFF_FFC3};

        for (int e = 0; e < DEPTH; e++) gen_m[e] = 1'b0;
        reset = 1'b1; flush = 1'b0; alloc_valid = '0; alloc_addr = '0; alloc_size = '0;
        alloc_unsigned = '0; alloc_tag = '0; fwd_hit = 1'b0; fwd_block = 1'b0; fwd_data = '0;
        done_ack = 1'b0;
        clr_mem;
        tick;
        tick;
        reset = 1'b0;
        check_idle("reset");

        // Extraction vectors through the dcache path, one load at a time in entry 0.
        for (int i = 0; i < 9; i++) begin
            int rp;
            rp = i % 2;
            alloc1(0, vecs[i].addr, vecs[i].size, vecs[i].uns, 6'(i + 20));
            miss_cycles(1);
            expect_req(0, 0);
            check("mem_req_addr", mem_req_addr[0], vecs[i].addr);
            mem_req_accept     = 2'b01;
            mem_resp_valid[rp] = 1'b1;
            mem_resp_id[rp]    = id_of(0);
            mem_resp_data[rp]  = vecs[i].word;
            push(6'(i + 20), vecs[i].exp);
            tick;
            clr_mem;
            check("done_valid_latency", 32'(done_valid), 32'd1);
            collect;
        end

`ifdef LQ_FWD_EN
        // Forward hit: done two cycles after allocation.
        alloc1(0, 32'h0000_0103, 2'd0, 1'b0, 6'd5);
        check("fwd_req", 32'(fwd_req), 32'd1);
        check("fwd_addr", fwd_addr, 32'h0000_0103);
        check("fwd_size", 32'(fwd_size), 32'd0);
        fwd_hit  = 1'b1;
        fwd_data = 32'h80FF_FF00;
        push(6'd5, 32'hFFFF_FF80);
        tick;
        fwd_hit = 1'b0;
        check("fwd_hit_done", 32'(done_valid), 32'd1);
        check("fwd_hit_no_mem", 32'(mem_req_valid), 32'd0);
        collect;

        // Dual allocation with a blocked lookup.
        alloc2(0, 1, 32'h0000_0500, 32'h0000_0504, 6'd10, 6'd11);
        fwd_block = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("blocked_fwd_addr", fwd_addr, 32'h0000_0500);
            check("blocked_no_mem", 32'(mem_req_valid), 32'd0);
            tick;
        end
        fwd_block = 1'b0;
        check("unblocked_fwd_addr", fwd_addr, 32'h0000_0500);
        tick;
        check("second_lookup_addr", fwd_addr, 32'h0000_0504);
        check("one_mem_req", 32'(mem_req_valid), 32'd1);
        expect_req(0, 0);
        mem_req_accept = 2'b01;
        tick;
        clr_mem;
        check("entry1_mem_req", 32'(mem_req_valid), 32'd1);
        expect_req(0, 1);
        mem_req_accept = 2'b01;
        tick;
        clr_mem;
        check("both_wait", 32'(mem_req_valid), 32'd0);
        mem_resp_valid   = 2'b11;
        mem_resp_id[0]   = id_of(1);
        mem_resp_data[0] = 32'h0000_1111;
        mem_resp_id[1]   = id_of(0);
        mem_resp_data[1] = 32'h2222_0000;
        push(6'd10, 32'h2222_0000);
        push(6'd11, 32'h0000_1111);
        tick;
        clr_mem;
        collect;
        collect;
`endif

        // Reject for two cycles, then the unaccepted entry moves to port 0.
        alloc2(0, 1, 32'h0000_0700, 32'h0000_0704, 6'd7, 6'd8);
        miss_cycles(2);
        for (int k = 0; k < 2; k++) begin
            check("rejected_pair_valid", 32'(mem_req_valid), 32'd3);
            expect_req(0, 0);
            expect_req(1, 1);
            tick;
        end
        mem_req_accept = 2'b01;
        tick;
        clr_mem;
        check("moved_valid", 32'(mem_req_valid), 32'd1);
        expect_req(0, 1);
        mem_req_accept   = 2'b01;
        mem_resp_valid   = 2'b11;
        mem_resp_id[0]   = id_of(1);
        mem_resp_data[0] = 32'hCAFE_F00D;
        mem_resp_id[1]   = id_of(0);
        mem_resp_data[1] = 32'h1357_9BDF;
        push(6'd7, 32'h1357_9BDF);
        push(6'd8, 32'hCAFE_F00D);
        tick;
        clr_mem;
        collect;
        collect;

        // Fill to DEPTH, complete entry 0, ack: one slot free the next cycle.
`ifdef LQ_FWD_EN
        fwd_block = 1'b1;
`endif
        for (int k = 0; k < 4; k++) begin
            check("fill_ready", 32'(alloc_ready), 32'd3);
            alloc2(2 * k, 2 * k + 1, 32'h600 + 32'(8 * k), 32'h604 + 32'(8 * k),
                   6'(30 + 2 * k), 6'(31 + 2 * k));
        end
        check("full_ready", 32'(alloc_ready), 32'd0);
`ifdef LQ_FWD_EN
        check("fill_fwd_addr", fwd_addr, 32'h0000_0600);
        fwd_block = 1'b0;
        fwd_hit   = 1'b1;
        fwd_data  = 32'h1111_2222;
        push(6'd30, 32'h1111_2222);
        tick;
        fwd_hit   = 1'b0;
        fwd_block = 1'b1;
`else
        expect_req(0, 0);
        mem_req_accept   = 2'b01;
        mem_resp_valid   = 2'b01;
        mem_resp_id[0]   = id_of(0);
        mem_resp_data[0] = 32'h1111_2222;
        push(6'd30, 32'h1111_2222);
        tick;
        clr_mem;
`endif
        check("full_before_ack", 32'(alloc_ready), 32'd0);
        check("fill_done_valid", 32'(done_valid), 32'd1);
        collect;
        check("ready_after_ack", 32'(alloc_ready), 32'd1);

        // Flush discards a same-cycle allocation.
        flush       = 1'b1;
        alloc_valid = 2'b01;
        tick;
        flush       = 1'b0;
        alloc_valid = '0;
        fwd_block   = 1'b0;
        check_idle("flush");

        // In-flight request squashed; stale response must be dropped.
        alloc2(0, 1, 32'h0000_0800, 32'h0000_0804, 6'd40, 6'd41);
        alloc2(2, 3, 32'h0000_0808, 32'h0000_080C, 6'd42, 6'd43);
        miss_cycles(4);
        accept_pair(0, 1);
        accept_pair(2, 3);
        stale_id = id_of(3);
        check("stale_id_gen0", 32'(stale_id), 32'h3);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check_idle("flush_inflight");
        alloc2(0, 1, 32'h0000_0900, 32'h0000_0904, 6'd50, 6'd51);
        alloc2(2, 3, 32'h0000_0908, 32'h0000_090C, 6'd52, 6'd53);
        miss_cycles(4);
        accept_pair(0, 1);
        accept_pair(2, 3);
        mem_resp_valid   = 2'b01;
        mem_resp_id[0]   = stale_id;
        mem_resp_data[0] = 32'hBAD0_BAD0;
        tick;
        clr_mem;
        for (int k = 0; k < 3; k++) begin
            check("stale_ignored", 32'(done_valid), 32'd0);
            tick;
        end
        mem_resp_valid   = 2'b10;
        mem_resp_id[1]   = id_of(3);
        mem_resp_data[1] = 32'h0000_5353;
        push(6'd53, 32'h0000_5353);
        tick;
        clr_mem;
        check("fresh_done", 32'(done_valid), 32'd1);
        collect;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_queue_mc.md
# load_queue_mc

Parametrised multi-channel load queue for the out-of-order core. It sits between the load reservation stations/address FUs and the data cache. It accepts up to `NUM_IN` address-resolved loads per cycle and checks each against the store queue for forwarding. Loads that do not forward are issued to up to `NUM_MEM` dcache ports, with retry on reject. Finished loads are written back one per cycle to the completion path, and the whole queue can be squashed on a flush.

## Interface
Parameters:
- `NUM_IN`, 2: allocation channels per cycle.
- `DEPTH`, 8: entries; power of two, `DEPTH >= NUM_IN`.
- `NUM_MEM`, 2: dcache request/response ports.
- `TAG_W`, 6: destination physical-register tag width.
- `ID_W`, `$clog2(DEPTH)+1`: request ID width (entry index plus generation bit).

Ports:
- `clock`  in  1  clock; one clock domain; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash all entries.
- `alloc_valid`  in  `NUM_IN`  load presented on channel i.
- `alloc_addr`  in  `NUM_IN`×32  byte address.
- `alloc_size`  in  `NUM_IN`×2  0=byte, 1=half, 2=word.
- `alloc_unsigned`  in  `NUM_IN`  zero-extend if 1, sign-extend if 0.
- `alloc_tag`  in  `NUM_IN`×`TAG_W`  destination tag.
- `alloc_ready`  out  `NUM_IN`  bit i high iff free entries > i.
- `fwd_req`  out  1  forward lookup valid.
- `fwd_addr`  out  32  lookup address.
- `fwd_size`  out  2  lookup size.
- `fwd_hit`  in  1  store queue supplies the data, same cycle.
- `fwd_block`  in  1  older store unresolved or partial overlap; retry.
- `fwd_data`  in  32  word-aligned store data.
- `mem_req_valid`  out  `NUM_MEM`  dcache request.
- `mem_req_addr`  out  `NUM_MEM`×32  request address.
- `mem_req_id`  out  `NUM_MEM`×`ID_W`  request ID.
- `mem_req_accept`  in  `NUM_MEM`  request taken.
- `mem_resp_valid`  in  `NUM_MEM`  response valid.
- `mem_resp_id`  in  `NUM_MEM`×`ID_W`  response ID.
- `mem_resp_data`  in  `NUM_MEM`×32  aligned word.
- `done_valid`  out  1  completed load available.
- `done_tag`  out  `TAG_W`  its tag.
- `done_data`  out  32  extended result.
- `done_ack`  in  1  completion consumed.

## Operation
- Each entry has a 5-state FSM: FREE, FWD, MEM, WAIT, DONE. It also holds a 1-bit generation `gen`.
- **Allocation**
  - The accepted channels, in channel order, take the lowest-index FREE entries. An accepted channel is one with `alloc_valid[i] & alloc_ready[i]`.
  - The new entry enters FWD and toggles its `gen`.
  - `alloc_ready` is computed from registered state only. An entry freed this cycle is reusable the next cycle.
- **FWD**
  - The lowest-index FWD entry drives `fwd_req`, `fwd_addr` and `fwd_size`.
  - If `fwd_hit & !fwd_block`, the entry captures the extracted data and goes to DONE.
  - If `fwd_block`, the entry stays in FWD.
  - Otherwise the entry goes to MEM.
- **MEM**
  - The k lowest-index MEM entries (k ≤ `NUM_MEM`) drive ports 0..k-1.
  - `mem_req_id` is `{gen, index}`.
  - On accept, the entry goes to WAIT. Without accept, it stays in MEM and is re-presented next cycle, possibly on another port.
- **WAIT**
  - A response is matched when `mem_resp_valid[p]` is set and `mem_resp_id[p]` equals `{gen, index}` of an entry in WAIT.
  - On a match, the entry captures the data and goes to DONE. Non-matching responses are dropped; these are stale ones from before a flush.
- **DONE**
  - The lowest-index DONE entry drives `done_*`. On `done_ack` the entry goes to FREE.
- **Extraction**
  - The byte/half selected by `addr[1:0]` is shifted down, then sign- or zero-extended to 32 bits.
  - Addresses are naturally aligned for their size; the decoder guarantees this.
- **Flush**: every entry goes to FREE next cycle. Allocations, responses and acks in the same cycle are discarded. `gen` bits are preserved.

## Timing
- Reset values: every entry is FREE with `gen`=0; `alloc_ready` is all ones; all other outputs are 0.
- Reset has priority over flush; flush has priority over every other event.
- Allocation at posedge N: lookup at cycle N+1.
  - On a hit, `done_valid` at N+2.
  - Otherwise, the dcache request at N+2.
- Response at posedge M: `done_valid` at M+1.
- Minimum load-to-done latency is 2 cycles on a forward hit and 3 cycles via dcache, assuming zero-cycle dcache hit response.
- Full queue: `alloc_ready`=0.
- An entry acked at posedge N is allocatable at N+1, not N.
- A response arriving in the same cycle as its accept is legal and completes the entry.

## Configuration
- `LQ_FWD_EN` defined:
  - FWD state and store-queue lookup are present, as above.
- `LQ_FWD_EN` undefined:
  - No FWD state.
  - Allocation enters MEM directly.
  - `fwd_req`, `fwd_addr` and `fwd_size` are tied to 0; `fwd_*` inputs are ignored.
  - Minimum latency is 2 cycles via dcache.

## Test plan
- **Reset**: after reset, `alloc_ready`=2'b11, `done_valid`=0, `mem_req_valid`=0.
- **Forward hit**: alloc lb at addr 0x103, tag 5; fwd_hit with fwd_data=0x80FF_FF00 → `done_valid` 2 cycles later, `done_tag`=5, `done_data`=0xFFFF_FF80.
- **Dcache path with reject**: alloc lhu at 0x202, tag 7; fwd miss; `mem_req_accept`=0 for 2 cycles, then 1; response 0xABCD_1234 next cycle → `done_data`=0x0000_ABCD, tag 7.
- **Fill to DEPTH=8**: fill with 8 loads → `alloc_ready`=0. One `done_ack` → `alloc_ready[0]`=1 on the following cycle.
- **Flush with in-flight request**: flush while an entry is in WAIT (id {0,3}); realloc entry 3 (gen=1); stale response with id {0,3} → ignored, entry 3 stays WAIT until id {1,3} returns.
- **Dual-channel allocation with blocked lookup**: two simultaneous allocations → entries 0 and 1 used. `fwd_block` held 3 cycles → entry 0 stays in FWD, no mem request from it.
